// File: rtl/program_counter_stack_pkg.sv
// Shared types and helpers for the program counter with return stack.
package program_counter_stack_pkg;

  typedef enum logic [2:0] {
    OP_HOLD,
    OP_INC,
    OP_LOAD,
    OP_CALL,
    OP_RET
  } op_e;

  // Fixed priority: RET > CALL > LOAD > INC > hold.
  function automatic op_e decode_op(input logic ret, input logic call,
                                    input logic load, input logic inc);
    if (ret)       return OP_RET;
    else if (call) return OP_CALL;
    else if (load) return OP_LOAD;
    else if (inc)  return OP_INC;
    else           return OP_HOLD;
  endfunction

  function automatic int sp_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/program_counter_stack_if.sv
// Request/status bundle between a sequencer and the program counter stack.
interface program_counter_stack_if
  import program_counter_stack_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DEPTH = 8
);
  logic                           inc;
  logic                           load;
  logic                           call;
  logic                           ret;
  logic [WIDTH-1:0]               d;
  logic [WIDTH-1:0]               out;
  logic [sp_width(DEPTH)-1:0]     sp;
  logic                           full;
  logic                           empty;
  logic                           err;

  modport master (
    output inc, load, call, ret, d,
    input  out, sp, full, empty, err
  );

  modport slave (
    input  inc, load, call, ret, d,
    output out, sp, full, empty, err
  );
endinterface

// File: rtl/program_counter_stack_ret_stack.sv
// Return-address LIFO; only the occupancy count is reset, the data array is not.
module pc_ret_stack
  import program_counter_stack_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DEPTH = 8,
  localparam int SPW = sp_width(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] push_data,
  output logic [WIDTH-1:0] top,
  output logic [SPW-1:0]   count,
  output logic             full,
  output logic             empty
);
  // Storage rounded up to a power of two so the index never exceeds the array.
  localparam int AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int ENTRIES = 1 << AW;

  logic [WIDTH-1:0] mem [ENTRIES];
  logic [SPW-1:0]   cnt_q;
  logic [AW-1:0]    wr_idx;
  logic [AW-1:0]    rd_idx;

  assign wr_idx = cnt_q[AW-1:0];
  assign rd_idx = wr_idx - AW'(1);
  assign top    = mem[rd_idx];
  assign count  = cnt_q;
  assign full   = (cnt_q == SPW'(DEPTH));
  assign empty  = (cnt_q == '0);

  always_ff @(posedge clk) begin
    if (!rst_n)
      cnt_q <= '0;
    else if (push && !full)
      cnt_q <= cnt_q + SPW'(1);
    else if (pop && !empty)
      cnt_q <= cnt_q - SPW'(1);
  end

  always_ff @(posedge clk) begin
    if (rst_n && push && !full)
      mem[wr_idx] <= push_data;
  end

endmodule

// File: rtl/program_counter_stack.sv
// Program counter with increment, jump, call and return over a small return stack.
module program_counter_stack
  import program_counter_stack_pkg::*;
#(
  parameter int          WIDTH      = 16,
  parameter int          DEPTH      = 8,
  parameter int unsigned RESET_ADDR = 0
) (
  input  logic                    clk,
  input  logic                    rst_n,
  program_counter_stack_if.slave  bus
);
  op_e              op;
  logic [WIDTH-1:0] out_q;
  logic [WIDTH-1:0] next_pc;
  logic             err_q;
  logic             err_next;
  logic [WIDTH-1:0] ret_addr;
  logic [WIDTH-1:0] pc_plus1;
  logic             stk_full;
  logic             stk_empty;

  assign op       = decode_op(bus.ret, bus.call, bus.load, bus.inc);
  assign pc_plus1 = out_q + WIDTH'(1);

  pc_ret_stack #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_stack (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (op == OP_CALL),
    .pop       (op == OP_RET),
    .push_data (pc_plus1),
    .top       (ret_addr),
    .count     (bus.sp),
    .full      (stk_full),
    .empty     (stk_empty)
  );

  // Overflowing CALL and underflowing RET leave the PC in place and only flag.
  always_comb begin
    next_pc  = out_q;
    err_next = err_q;
    case (op)
      OP_INC:  next_pc = pc_plus1;
      OP_LOAD: next_pc = bus.d;
      OP_CALL: if (stk_full)  err_next = 1'b1; else next_pc = bus.d;
      OP_RET:  if (stk_empty) err_next = 1'b1; else next_pc = ret_addr;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_q <= WIDTH'(RESET_ADDR);
      err_q <= 1'b0;
    end else begin
      out_q <= next_pc;
      err_q <= err_next;
    end
  end

  assign bus.out   = out_q;
  assign bus.err   = err_q;
  assign bus.full  = stk_full;
  assign bus.empty = stk_empty;

endmodule

// File: tb/tb_program_counter_stack.sv
// Directed vector bench: DEPTH=8 instance via table, DEPTH=2 instance via hand sequence.
module tb_program_counter_stack;
  import program_counter_stack_pkg::*;

  logic clk = 1'b0;
  logic rst_n_a = 1'b1;
  logic rst_n_b = 1'b1;
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  program_counter_stack_if #(.WIDTH(16), .DEPTH(8)) bus_a ();
  program_counter_stack_if #(.WIDTH(16), .DEPTH(2)) bus_b ();

  program_counter_stack #(.WIDTH(16), .DEPTH(8), .RESET_ADDR(0)) u_dut_a (
    .clk   (clk),
    .rst_n (rst_n_a),
    .bus   (bus_a.slave)
  );

  program_counter_stack #(.WIDTH(16), .DEPTH(2), .RESET_ADDR(32'h0001_0005)) u_dut_b (
    .clk   (clk),
    .rst_n (rst_n_b),
    .bus   (bus_b.slave)
  );

  typedef struct {
    logic        rst_n;
    logic        inc;
    logic        load;
    logic        call;
    logic        ret;
    logic [15:0] d;
    logic [15:0] exp_out;
    int          exp_sp;
    logic        exp_full;
    logic        exp_empty;
    logic        exp_err;
  } vec_t;

  vec_t vecs [$];

  task automatic chk(input string name, input int idx, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s step %0d: got %h expected %h", name, idx, act, exp);
    end
  endtask

  task automatic add(input logic r, input logic i, input logic l, input logic c,
                     input logic t, input logic [15:0] d, input logic [15:0] eo,
                     input int es, input logic ef, input logic ee, input logic er);
    vec_t v;
    v.rst_n = r; v.inc = i; v.load = l; v.call = c; v.ret = t; v.d = d;
    v.exp_out = eo; v.exp_sp = es; v.exp_full = ef; v.exp_empty = ee; v.exp_err = er;
    vecs.push_back(v);
  endtask

  task automatic drive_b(input logic c, input logic t, input logic [15:0] d);
    bus_b.inc = 1'b0; bus_b.load = 1'b0; bus_b.call = c; bus_b.ret = t; bus_b.d = d;
  endtask

  task automatic chk_b(input string name, input int idx, input logic [15:0] eo,
                       input int es, input logic ef, input logic er);
    chk({name, "_out"},  idx, 32'(bus_b.out),  32'(eo));
    chk({name, "_sp"},   idx, 32'(bus_b.sp),   32'(es));
    chk({name, "_full"}, idx, 32'(bus_b.full), 32'(ef));
    chk({name, "_err"},  idx, 32'(bus_b.err),  32'(er));
  endtask

  initial begin
    //   rst inc ld cal ret d         out      sp full empty err
    add(0, 0, 0, 0, 0, 16'h0000, 16'h0000, 0, 0, 1, 0);
    add(1, 1, 0, 0, 0, 16'h0000, 16'h0001, 0, 0, 1, 0);
    add(1, 1, 0, 0, 0, 16'h0000, 16'h0002, 0, 0, 1, 0);
    add(1, 1, 0, 0, 0, 16'h0000, 16'h0003, 0, 0, 1, 0);
    add(1, 0, 1, 0, 0, 16'hFFFF, 16'hFFFF, 0, 0, 1, 0);
    add(1, 1, 0, 0, 0, 16'h0000, 16'h0000, 0, 0, 1, 0);
    add(1, 0, 1, 0, 0, 16'h0010, 16'h0010, 0, 0, 1, 0);
    add(1, 0, 0, 1, 0, 16'h0100, 16'h0100, 1, 0, 0, 0);
    add(1, 0, 0, 1, 0, 16'h0200, 16'h0200, 2, 0, 0, 0);
    add(1, 0, 0, 0, 1, 16'h0000, 16'h0101, 1, 0, 0, 0);
    add(1, 0, 0, 0, 1, 16'h0000, 16'h0011, 0, 0, 1, 0);
    add(1, 0, 1, 0, 0, 16'h0042, 16'h0042, 0, 0, 1, 0);
    add(1, 0, 0, 0, 1, 16'h0000, 16'h0042, 0, 0, 1, 1);
    add(1, 1, 0, 0, 0, 16'h0000, 16'h0043, 0, 0, 1, 1);
    add(1, 0, 0, 0, 0, 16'h0000, 16'h0043, 0, 0, 1, 1);
    add(0, 0, 0, 0, 0, 16'h0000, 16'h0000, 0, 0, 1, 0);
    add(1, 0, 1, 0, 0, 16'h0005, 16'h0005, 0, 0, 1, 0);
    add(1, 1, 1, 1, 0, 16'h0300, 16'h0300, 1, 0, 0, 0);
    add(1, 0, 0, 1, 1, 16'h0300, 16'h0006, 0, 0, 1, 0);
    add(1, 0, 0, 0, 0, 16'h0000, 16'h0006, 0, 0, 1, 0);
    add(1, 0, 1, 0, 0, 16'h0050, 16'h0050, 0, 0, 1, 0);
    add(0, 0, 0, 1, 0, 16'h0777, 16'h0000, 0, 0, 1, 0);
    add(1, 0, 0, 0, 0, 16'h0000, 16'h0000, 0, 0, 1, 0);
    add(1, 0, 0, 0, 1, 16'h0000, 16'h0000, 0, 0, 1, 1);

    bus_a.inc = 1'b0; bus_a.load = 1'b0; bus_a.call = 1'b0; bus_a.ret = 1'b0; bus_a.d = '0;
    drive_b(1'b0, 1'b0, 16'h0000);
    bus_b.inc = 1'b0; bus_b.load = 1'b0;

    @(negedge clk);
    for (int i = 0; i < vecs.size(); i++) begin
      rst_n_a    = vecs[i].rst_n;
      bus_a.inc  = vecs[i].inc;
      bus_a.load = vecs[i].load;
      bus_a.call = vecs[i].call;
      bus_a.ret  = vecs[i].ret;
      bus_a.d    = vecs[i].d;
      @(negedge clk);
      chk("a_out",   i, 32'(bus_a.out),   32'(vecs[i].exp_out));
      chk("a_sp",    i, 32'(bus_a.sp),    32'(vecs[i].exp_sp));
      chk("a_full",  i, 32'(bus_a.full),  32'(vecs[i].exp_full));
      chk("a_empty", i, 32'(bus_a.empty), 32'(vecs[i].exp_empty));
      chk("a_err",   i, 32'(bus_a.err),   32'(vecs[i].exp_err));
    end
    rst_n_a = 1'b1;
    bus_a.inc = 1'b0; bus_a.load = 1'b0; bus_a.call = 1'b0; bus_a.ret = 1'b0;

    // DEPTH=2 overflow; RESET_ADDR above 16 bits truncates to 0x0005.
    rst_n_b = 1'b0;
    drive_b(1'b0, 1'b0, 16'h0000);
    @(negedge clk);
    chk_b("b_reset", 0, 16'h0005, 0, 1'b0, 1'b0);
    chk("b_empty", 0, 32'(bus_b.empty), 32'd1);
    rst_n_b = 1'b1;
    drive_b(1'b1, 1'b0, 16'h000A);
    @(negedge clk);
    chk_b("b_call1", 1, 16'h000A, 1, 1'b0, 1'b0);
    drive_b(1'b1, 1'b0, 16'h000B);
    @(negedge clk);
    chk_b("b_call2", 2, 16'h000B, 2, 1'b1, 1'b0);
    drive_b(1'b1, 1'b0, 16'h000C);
    @(negedge clk);
    chk_b("b_call3", 3, 16'h000B, 2, 1'b1, 1'b1);
    drive_b(1'b0, 1'b1, 16'h0000);
    @(negedge clk);
    chk_b("b_ret1", 4, 16'h000B, 1, 1'b0, 1'b1);
    @(negedge clk);
    chk_b("b_ret2", 5, 16'h0006, 0, 1'b0, 1'b1);
    chk("b_empty", 5, 32'(bus_b.empty), 32'd1);
    drive_b(1'b0, 1'b0, 16'h0000);
    @(negedge clk);
    chk_b("b_hold", 6, 16'h0006, 0, 1'b0, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/program_counter_stack.md
PROGRAM_COUNTER_STACK -- requirements
Module: program_counter_stack

Interface
REQ-001 Parameter WIDTH, default 16: program-counter and data width in bits, range 2..32.
REQ-002 Parameter DEPTH, default 8: return-stack entries, range 1..64.
REQ-003 Parameter RESET_ADDR, default 0: OUT value after reset, truncated to WIDTH.
REQ-004 The block SHALL use one clock; reset is synchronous and active-low.
REQ-005 Port CLK, input, 1: sole clock; all state updates on its rising edge.
REQ-006 Port RST_N, input, 1: synchronous active-low reset.
REQ-007 Port INC, input, 1: advance OUT by one.
REQ-008 Port LOAD, input, 1: OUT takes D.
REQ-009 Port CALL, input, 1: push OUT+1 onto the return stack, and OUT takes D.
REQ-010 Port RET, input, 1: OUT takes the top of the stack, then the stack is popped.
REQ-011 Port D, input, WIDTH: jump or call target.
REQ-012 Port OUT, output, WIDTH: current program counter, registered.
REQ-013 Port SP, output, clog2(DEPTH+1): number of occupied stack entries, registered.
REQ-014 Ports FULL and EMPTY, output, 1 each: FULL is SP==DEPTH; EMPTY is SP==0; both combinational from SP.
REQ-015 Port ERR, output, 1: sticky flag for stack overflow or underflow, registered.

Function
REQ-016 The block SHALL act on exactly one operation per cycle, chosen by fixed priority RET > CALL > LOAD > INC > hold.
REQ-017 Lower-priority requests asserted in the same cycle SHALL be ignored with no side effect.
REQ-018 OUT and SP SHALL show the effect of a cycle-N operation from cycle N+1; latency is one cycle and there is no combinational path from inputs to OUT.
REQ-019 INC: OUT <= (OUT+1) mod 2^WIDTH; all-ones SHALL wrap to 0 without setting ERR.
REQ-020 LOAD: OUT <= D; the stack SHALL be unchanged.
REQ-021 CALL with FULL=0 SHALL perform three actions:
- write (OUT+1) mod 2^WIDTH to entry SP;
- SP <= SP+1;
- OUT <= D.
REQ-022 CALL with FULL=1 SHALL leave OUT, SP and stack contents unchanged and SHALL set ERR.
REQ-023 RET with EMPTY=0 SHALL set OUT <= entry SP-1 and SP <= SP-1.
REQ-024 RET with EMPTY=1 SHALL leave OUT and SP unchanged and SHALL set ERR.
REQ-025 A RET on the cycle directly after a CALL SHALL return the address pushed by that CALL (read-after-write through the same cycle boundary).
REQ-026 ERR SHALL remain 1 until reset; later legal operations SHALL NOT clear it.
REQ-027 Hold (no request asserted) SHALL keep every register unchanged.

Reset
REQ-028 While RST_N=0 at a rising edge, the block SHALL set OUT <= RESET_ADDR, SP <= 0 and ERR <= 0, overriding all requests.
REQ-029 Stack storage contents SHALL NOT be reset; entries at index >= SP are don't-care.
REQ-030 Reset asserted in the same cycle as a CALL SHALL discard the push; SP SHALL read 0 afterwards.
REQ-031 After reset, FULL=0 and EMPTY=1 (DEPTH>=1).

Structure
REQ-032 A shared package SHALL hold:
- the operation enumeration OP_HOLD, OP_INC, OP_LOAD, OP_CALL, OP_RET;
- the priority-decode function;
- the width helper for SP.
REQ-033 Return-address storage SHALL be one sub-module, pc_ret_stack: DEPTH x WIDTH LIFO with push, pop, top and count, no reset on the data array.
REQ-034 The top level SHALL contain only the decode logic, the OUT register, the ERR flag and the next-PC multiplexer.

Verification
REQ-035 Reset and wrap (WIDTH=16): RST_N=0 for one edge, then INC x3 -> OUT=0,1,2,3. Then LOAD D=0xFFFF, then INC -> OUT=0xFFFF, then 0x0000, ERR=0.
REQ-036 Nested calls (DEPTH=8): at OUT=0x0010, CALL D=0x0100, then CALL D=0x0200, then RET, RET.
- Expected OUT sequence: 0x0100, 0x0200, 0x0101, 0x0011.
- Expected SP sequence: 1, 2, 1, 0.
REQ-037 Overflow (DEPTH=2): three CALLs D=0x0A, 0x0B, 0x0C.
- After the third CALL: OUT=0x0B, SP=2, FULL=1, ERR=1.
- Two RETs then return in LIFO order, and ERR stays 1.
REQ-038 Underflow: RET with SP=0 at OUT=0x0042 -> OUT=0x0042, SP=0, ERR=1. A following INC gives OUT=0x0043 with ERR still 1.
REQ-039 Priority: at OUT=5, one cycle with INC=LOAD=CALL=1, D=0x0300 -> OUT=0x0300, SP=1.
- Next cycle RET=CALL=1 -> OUT=6, SP=0.
REQ-040 Reset mid-operation: RST_N=0 coincident with CALL D=0x0777 -> OUT=RESET_ADDR, SP=0, ERR=0, EMPTY=1.
